// File: rtl/preg_alloc_arbiter.sv
// Round-robin arbiter sharing the physical-register freelist through a small prefetch FIFO.
// Define PREG_ALLOC_STATS_EN to add the stat_grants/stat_stalls counters.
module preg_alloc_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int PREG_WIDTH = 6,
    parameter int PF_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [PREG_WIDTH-1:0] gnt_preg,
    output logic                  alloc_ready,
    input  logic                  flush,
    output logic                  fl_dequeue,
    input  logic [PREG_WIDTH-1:0] fl_data_out,
    input  logic                  fl_empty,
    output logic                  fl_enqueue,
    output logic [PREG_WIDTH-1:0] fl_data_in,
    input  logic                  fl_full
`ifdef PREG_ALLOC_STATS_EN
    ,
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_stalls
`endif
);

    localparam int PW = $clog2(PF_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(NUM_REQ);
    localparam logic [CW-1:0] DEPTH_C = CW'(PF_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [PREG_WIDTH-1:0] fifo_r [PF_DEPTH];
    logic [PW-1:0]         head_r;
    logic [PW-1:0]         tail_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic [RW-1:0]         rr_r;
    logic [RW-1:0]         rr_next_s;
    logic [RW-1:0]         idx_s;
    logic                  found_s;
    logic                  run_s;
    logic                  push_s;
    logic                  pop_s;

    // Round-robin grant search starting at rr_r; only offered when the FIFO holds an ID.
    always_comb begin
        gnt       = '0;
        rr_next_s = rr_r;
        found_s   = 1'b0;
        idx_s     = '0;
        if (!rst && run_s && !flush && count_r != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_s = RW'((int'(rr_r) + i) % NUM_REQ);
                if (!found_s && req[idx_s]) begin
                    found_s    = 1'b1;
                    gnt[idx_s] = 1'b1;
                    rr_next_s  = RW'((int'(idx_s) + 1) % NUM_REQ);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // Freelist strobes, status, FIFO bookkeeping and next state.
    always_comb begin
        run_s        = (state_r == RUN);
        fl_dequeue   = !rst && run_s && !flush && !fl_empty && (count_r < DEPTH_C);
        fl_enqueue   = !rst && (state_r == DRAIN) && !fl_full;
        alloc_ready  = !rst && run_s && (count_r != '0);
        gnt_preg     = fifo_r[head_r];
        fl_data_in   = fifo_r[head_r];
        push_s       = fl_dequeue;
        pop_s        = (|gnt) || fl_enqueue;
        count_next_s = count_r + CW'(push_s) - CW'(pop_s);
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (flush && count_next_s != '0) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (pop_s && count_r == CW'(1)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = RUN;
        endcase
    end

    // Control state: pointers, occupancy, round-robin pointer and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            rr_r    <= '0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            rr_r    <= rr_next_s;
            if (push_s) tail_r <= tail_r + PW'(1);
            if (pop_s)  head_r <= head_r + PW'(1);
        end
    end

    // Prefetch storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) fifo_r[tail_r] <= fl_data_out;
    end

`ifdef PREG_ALLOC_STATS_EN
    // Free-running wrap-around activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= 32'd0;
            stat_stalls <= 32'd0;
        end else begin
            if (|gnt) stat_grants <= stat_grants + 32'd1;
            if ((|req) && !(|gnt)) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_preg_alloc_arbiter.sv
// Directed table-driven bench for preg_alloc_arbiter (NUM_REQ=2, PREG_WIDTH=6, PF_DEPTH=4).
module tb_preg_alloc_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [5:0] gnt_preg;
    logic       alloc_ready;
    logic       flush;
    logic       fl_dequeue;
    logic [5:0] fl_data_out;
    logic       fl_empty;
    logic       fl_enqueue;
    logic [5:0] fl_data_in;
    logic       fl_full;
`ifdef PREG_ALLOC_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_stalls;
    logic [31:0] g0;
    logic [31:0] s0;
`endif

    int tests = 0;
    int fails = 0;

    preg_alloc_arbiter #(.NUM_REQ(2), .PREG_WIDTH(6), .PF_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_preg(gnt_preg),
        .alloc_ready(alloc_ready), .flush(flush), .fl_dequeue(fl_dequeue),
        .fl_data_out(fl_data_out), .fl_empty(fl_empty), .fl_enqueue(fl_enqueue),
        .fl_data_in(fl_data_in), .fl_full(fl_full)
`ifdef PREG_ALLOC_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic       flush;
        logic       fl_empty;
        logic [5:0] data;
        logic       fl_full;
        logic [1:0] gnt;
        logic [5:0] preg;
        logic       deq;
        logic       enq;
        logic [5:0] din;
        logic       ready;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [1:0] r, logic f, logic e, logic [5:0] d, logic ff,
                                logic [1:0] g, logic [5:0] p, logic dq, logic eq,
                                logic [5:0] di, logic rd);
        vec_t v;
        v.req = r; v.flush = f; v.fl_empty = e; v.data = d; v.fl_full = ff;
        v.gnt = g; v.preg = p; v.deq = dq; v.enq = eq; v.din = di; v.ready = rd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [1:0] r, logic f, logic e, logic [5:0] d, logic ff);
        req = r; flush = f; fl_empty = e; fl_data_out = d; fl_full = ff;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              req    fl  emp data   full  gnt    preg   deq   enq   din    rdy
        // Prefetch fill 32..35; 36 refused at count=4
        vecs[0]  = mk(2'b00, 1'b0, 1'b0, 6'd32, 1'b0, 2'b00, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0);
        vecs[1]  = mk(2'b00, 1'b0, 1'b0, 6'd33, 1'b0, 2'b00, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1);
        vecs[2]  = mk(2'b00, 1'b0, 1'b0, 6'd34, 1'b0, 2'b00, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1);
        vecs[3]  = mk(2'b00, 1'b0, 1'b0, 6'd35, 1'b0, 2'b00, 6'd0,  1'b1, 1'b0, 6'd0,  1'b1);
        vecs[4]  = mk(2'b00, 1'b0, 1'b0, 6'd36, 1'b0, 2'b00, 6'd0,  1'b0, 1'b0, 6'd0,  1'b1);
        // Round-robin grants with concurrent refill 40,41,42 (no fill-through while full)
        vecs[5]  = mk(2'b11, 1'b0, 1'b0, 6'd50, 1'b0, 2'b01, 6'd32, 1'b0, 1'b0, 6'd0,  1'b1);
        vecs[6]  = mk(2'b11, 1'b0, 1'b0, 6'd40, 1'b0, 2'b10, 6'd33, 1'b1, 1'b0, 6'd0,  1'b1);
        vecs[7]  = mk(2'b11, 1'b0, 1'b0, 6'd41, 1'b0, 2'b01, 6'd34, 1'b1, 1'b0, 6'd0,  1'b1);
        vecs[8]  = mk(2'b11, 1'b0, 1'b0, 6'd42, 1'b0, 2'b10, 6'd35, 1'b1, 1'b0, 6'd0,  1'b1);
        // Flush with {40,41,42} queued, then drain with a fl_full stall and an ignored flush
        vecs[9]  = mk(2'b11, 1'b1, 1'b0, 6'd60, 1'b0, 2'b00, 6'd0,  1'b0, 1'b0, 6'd0,  1'b1);
        vecs[10] = mk(2'b11, 1'b0, 1'b0, 6'd61, 1'b0, 2'b00, 6'd0,  1'b0, 1'b1, 6'd40, 1'b0);
        vecs[11] = mk(2'b11, 1'b0, 1'b0, 6'd62, 1'b1, 2'b00, 6'd0,  1'b0, 1'b0, 6'd41, 1'b0);
        vecs[12] = mk(2'b11, 1'b0, 1'b0, 6'd63, 1'b1, 2'b00, 6'd0,  1'b0, 1'b0, 6'd41, 1'b0);
        vecs[13] = mk(2'b11, 1'b1, 1'b0, 6'd1,  1'b0, 2'b00, 6'd0,  1'b0, 1'b1, 6'd41, 1'b0);
        vecs[14] = mk(2'b11, 1'b0, 1'b0, 6'd2,  1'b0, 2'b00, 6'd0,  1'b0, 1'b1, 6'd42, 1'b0);
        // Back in RUN: empty FIFO gives no bypass grant, prefetch resumes
        vecs[15] = mk(2'b11, 1'b0, 1'b0, 6'd7,  1'b0, 2'b00, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0);
        vecs[16] = mk(2'b01, 1'b0, 1'b1, 6'd0,  1'b0, 2'b01, 6'd7,  1'b0, 1'b0, 6'd0,  1'b1);
        // rr_ptr=1 with only req[0]: search wraps around
        vecs[17] = mk(2'b00, 1'b0, 1'b0, 6'd9,  1'b0, 2'b00, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0);
        vecs[18] = mk(2'b01, 1'b0, 1'b1, 6'd0,  1'b0, 2'b01, 6'd9,  1'b0, 1'b0, 6'd0,  1'b1);
        // Empty freelist and empty FIFO: request stalls
        vecs[19] = mk(2'b01, 1'b0, 1'b1, 6'd0,  1'b0, 2'b00, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0);
        vecs[20] = mk(2'b01, 1'b0, 1'b1, 6'd0,  1'b0, 2'b00, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0);
        vecs[21] = mk(2'b01, 1'b0, 1'b1, 6'd0,  1'b0, 2'b00, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0);

        // Reset held for two cycles
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 6'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_deq", 32'(fl_dequeue), 32'd0);
            chk("rst_enq", 32'(fl_enqueue), 32'd0);
            chk("rst_ready", 32'(alloc_ready), 32'd0);
            tick();
        end
        rst = 1'b0;
`ifdef PREG_ALLOC_STATS_EN
        @(negedge clk);
        chk("rst_stat_grants", stat_grants, 32'd0);
        chk("rst_stat_stalls", stat_stalls, 32'd0);
        tick();
`endif

        for (int i = 0; i < NV; i++) begin
`ifdef PREG_ALLOC_STATS_EN
            g0 = stat_grants;
            s0 = stat_stalls;
`endif
            drive(vecs[i].req, vecs[i].flush, vecs[i].fl_empty, vecs[i].data, vecs[i].fl_full);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_deq", i), 32'(fl_dequeue), 32'(vecs[i].deq));
            chk($sformatf("v%0d_enq", i), 32'(fl_enqueue), 32'(vecs[i].enq));
            chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].ready));
            if (vecs[i].gnt != 2'b00) chk($sformatf("v%0d_preg", i), 32'(gnt_preg), 32'(vecs[i].preg));
            if (vecs[i].enq || vecs[i].fl_full) chk($sformatf("v%0d_din", i), 32'(fl_data_in), 32'(vecs[i].din));
            tick();
`ifdef PREG_ALLOC_STATS_EN
            if (i >= 19) begin
                chk($sformatf("v%0d_stat_stalls", i), stat_stalls, s0 + 32'd1);
                chk($sformatf("v%0d_stat_grants", i), stat_grants, g0);
            end
            if (i == 16) chk("v16_stat_grants", stat_grants, g0 + 32'd1);
`endif
        end

        // Reset in the middle of a drain discards the queued IDs
        drive(2'b00, 1'b0, 1'b0, 6'd20, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 6'd21, 1'b0);
        tick();
        drive(2'b00, 1'b1, 1'b1, 6'd0, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b1, 6'd0, 1'b0);
        @(negedge clk);
        chk("drain_enq", 32'(fl_enqueue), 32'd1);
        chk("drain_din", 32'(fl_data_in), 32'd20);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_enq", 32'(fl_enqueue), 32'd0);
        tick();
        rst = 1'b0;
        drive(2'b01, 1'b0, 1'b1, 6'd0, 1'b0);
        @(negedge clk);
        chk("post_rst_enq", 32'(fl_enqueue), 32'd0);
        chk("post_rst_gnt", 32'(gnt), 32'd0);
        chk("post_rst_ready", 32'(alloc_ready), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
